// File: rtl/stream_loader.sv
// Register-driven stream loader: buffers data words in a show-ahead FIFO, streams them
// downstream with valid/ready, then captures the single result word.
module stream_loader #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ctrl_wr,
   input  logic [31:0] ctrl_data,
   input  logic        data_wr,
   input  logic [31:0] data_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   input  logic        res_valid,
   input  logic [31:0] res_data,
   output logic [31:0] status,
   output logic [31:0] answer
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_RES, DONE} state_t;

   state_t state, state_next;

   logic [31:0]      mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      level;
   logic [CNT_W-1:0] n_reg, accepted, sent;
   logic             overflow, drop_err;

   logic abort, start, flush, clear, latch_n, push, pop;
   logic set_ovf, set_drop, capture, zero_answer;
   logic [CNT_W-1:0] ctrl_n;
   logic unused_ctrl_bits;

   assign abort  = ctrl_wr & ctrl_data[30];
   assign start  = ctrl_wr & ctrl_data[31];
   assign ctrl_n = ctrl_data[CNT_W-1:0];
   assign unused_ctrl_bits = ^ctrl_data[29:CNT_W];

   assign out_valid = (state == LOAD) && (level != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : 32'h0;
   assign out_last  = out_valid && (sent == n_reg - 1'b1);
   assign status    = {16'(sent), 8'(level), 4'b0000, drop_err,
                       (state == LOAD) || (state == WAIT_RES), overflow, state == DONE};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Abort beats everything; a start from IDLE/DONE restarts the job; otherwise the
   // current state decides what data, handshake and result events mean.
   always_comb begin
      state_next  = state;
      flush       = 1'b0;
      clear       = 1'b0;
      latch_n     = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      set_ovf     = 1'b0;
      set_drop    = 1'b0;
      capture     = 1'b0;
      zero_answer = 1'b0;
      if (abort) begin
         state_next = IDLE;
         flush      = 1'b1;
         clear      = 1'b1;
      end else if (start && (state == IDLE || state == DONE)) begin
         flush   = 1'b1;
         clear   = 1'b1;
         latch_n = 1'b1;
         if (ctrl_n == '0) begin
            state_next  = DONE;
            set_drop    = 1'b1;
            zero_answer = 1'b1;
         end else begin
            state_next = LOAD;
         end
      end else begin
         if (start) set_drop = 1'b1;
         case (state)
            LOAD: begin
               if (data_wr) begin
                  if (accepted == n_reg)       set_drop = 1'b1;
                  else if (level == FULL_LEVEL) set_ovf = 1'b1;
                  else                          push = 1'b1;
               end
               pop = out_valid && out_ready;
               if (pop && sent == n_reg - 1'b1) state_next = WAIT_RES;
            end
            WAIT_RES: begin
               if (data_wr) set_drop = 1'b1;
               if (res_valid) begin
                  capture    = 1'b1;
                  state_next = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   // FIFO bookkeeping, job counters and sticky flags; flush/clear reset them for a new job.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         n_reg    <= '0;
         accepted <= '0;
         sent     <= '0;
         overflow <= 1'b0;
         drop_err <= 1'b0;
         answer   <= 32'h0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
         end
         if (clear) begin
            accepted <= '0;
            sent     <= '0;
            n_reg    <= latch_n ? ctrl_n : '0;
            overflow <= 1'b0;
            drop_err <= set_drop;
         end else begin
            if (push) accepted <= accepted + 1'b1;
            if (pop)  sent     <= sent + 1'b1;
            if (set_ovf)  overflow <= 1'b1;
            if (set_drop) drop_err <= 1'b1;
         end
         if (zero_answer)  answer <= 32'h0;
         else if (capture) answer <= res_data;
      end
   end

endmodule

// File: tb/tb_stream_loader.sv
// Scoreboard bench for stream_loader: expected words are queued as they are written and a
// negedge monitor compares every handshake; status/answer are checked inline.
module tb_stream_loader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ctrl_wr = 1'b0;
   logic [31:0] ctrl_data = 32'h0;
   logic        data_wr = 1'b0;
   logic [31:0] data_in = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_last;
   logic        res_valid = 1'b0;
   logic [31:0] res_data = 32'h0;
   logic [31:0] status;
   logic [31:0] answer;

   int total = 0;
   int bad = 0;
   int pops_seen = 0;
   logic [32:0] exp_q[$];

   stream_loader #(.DEPTH(16), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .ctrl_wr(ctrl_wr), .ctrl_data(ctrl_data),
      .data_wr(data_wr), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .res_valid(res_valid), .res_data(res_data),
      .status(status), .answer(answer)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   // Every accepted handshake must match the next queued word and its last flag.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         pops_seen++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_word got=%h expected=none", out_data);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if ({out_last, out_data} !== e) begin
               bad++;
               $display("[TB] FAIL stream_word got=%h expected=%h", {out_last, out_data}, e);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ctrl_write(input logic [31:0] w);
      ctrl_wr = 1'b1;
      ctrl_data = w;
      cyc();
      ctrl_wr = 1'b0;
   endtask

   task automatic data_write(input logic [31:0] w, input bit expect_out, input bit last);
      data_wr = 1'b1;
      data_in = w;
      if (expect_out) exp_q.push_back({last, w});
      cyc();
      data_wr = 1'b0;
   endtask

   task automatic result_pulse(input logic [31:0] w);
      res_valid = 1'b1;
      res_data = w;
      cyc();
      res_valid = 1'b0;
   endtask

   initial begin
      int pops_before;
      #25 reset_n = 1'b1;
      cyc();
      check("reset_status", status, 32'h0);
      check("reset_answer", answer, 32'h0);
      check("reset_valid", {31'b0, out_valid}, 32'h0);
      check("reset_last", {31'b0, out_last}, 32'h0);

      // Job of three words with downstream always ready
      out_ready = 1'b1;
      ctrl_write(32'h8000_0003);
      check("t1_busy", status, 32'h0000_0004);
      data_write(32'hA, 1, 0);
      data_write(32'hB, 1, 0);
      data_write(32'hC, 1, 1);
      cyc();
      check("t1_wait_res", status, 32'h0003_0004);
      result_pulse(32'h1234);
      check("t1_answer", answer, 32'h0000_1234);
      check("t1_status", status, 32'h0003_0001);
      check("t1_q_empty", exp_q.size(), 32'd0);

      // Overflow with a stalled consumer, then backpressure stability and drain
      out_ready = 1'b0;
      ctrl_write(32'h8000_0014);
      for (int i = 0; i < 17; i++) data_write(32'h100 + i, i < 16, 0);
      check("t2_overflow", status, 32'h0000_1006);
      check("t3_hold0", out_data, 32'h100);
      cyc();
      cyc();
      check("t3_hold2", out_data, 32'h100);
      check("t3_valid", {31'b0, out_valid}, 32'h1);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) cyc();
      check("t2_drained", status, 32'h0010_0006);
      check("t2_valid_low", {31'b0, out_valid}, 32'h0);
      check("t2_q_empty", exp_q.size(), 32'd0);
      ctrl_write(32'h4000_0000);
      check("t2_abort", status, 32'h0);

      // Extra word beyond N is dropped
      pops_before = pops_seen;
      ctrl_write(32'h8000_0002);
      data_write(32'h21, 1, 0);
      data_write(32'h22, 1, 1);
      data_write(32'h23, 0, 0);
      cyc();
      check("t4_drop", status, 32'h0002_000C);
      check("t4_count", pops_seen - pops_before, 32'd2);
      result_pulse(32'h55);
      check("t4_answer", answer, 32'h55);
      check("t4_done", status, 32'h0002_0009);

      // Abort in the middle of loading, then a clean single-word job
      out_ready = 1'b0;
      ctrl_write(32'h8000_0004);
      data_write(32'h31, 1, 0);
      data_write(32'h32, 1, 0);
      check("t5_valid_pre", {31'b0, out_valid}, 32'h1);
      ctrl_write(32'h4000_0000);
      exp_q.delete();
      check("t5_valid_abort", {31'b0, out_valid}, 32'h0);
      check("t5_status_abort", status, 32'h0);
      check("t5_answer_held", answer, 32'h55);
      out_ready = 1'b1;
      ctrl_write(32'h8000_0001);
      data_write(32'h77, 1, 1);
      cyc();
      result_pulse(32'hBEEF);
      check("t5_answer", answer, 32'hBEEF);
      check("t5_status", status, 32'h0001_0001);

      // Asynchronous reset between clock edges in the middle of a transfer
      out_ready = 1'b0;
      ctrl_write(32'h8000_0005);
      data_write(32'h41, 1, 0);
      data_write(32'h42, 1, 0);
      #5 reset_n = 1'b0;
      #1;
      exp_q.delete();
      check("t6_status", status, 32'h0);
      check("t6_answer", answer, 32'h0);
      check("t6_valid", {31'b0, out_valid}, 32'h0);
      check("t6_last", {31'b0, out_last}, 32'h0);
      check("t6_data", out_data, 32'h0);
      #2 reset_n = 1'b1;
      cyc();
      ctrl_write(32'h8000_0000);
      check("t6_zero_job", status, 32'h0000_0009);
      check("t6_zero_answer", answer, 32'h0);
      check("final_q_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
